// File: rtl/mmv_pkg.sv
// Shared definitions for the memory-mapped splitter: address-decode helper
// and the widest address the helper accepts.
package mmv_pkg;

    localparam int unsigned MMV_ADDR_MAX = 64;

    // Extract the slave-select field (the top swidth bits of an awidth-bit
    // address). The address is passed zero-extended to MMV_ADDR_MAX bits,
    // so shifting right leaves only the select field in the low bits.
    function automatic logic [MMV_ADDR_MAX-1:0] mmv_slave_idx(
        input logic [MMV_ADDR_MAX-1:0] addr,
        input int unsigned             awidth,
        input int unsigned             swidth
    );
        logic [MMV_ADDR_MAX-1:0] mask;
        mask = (MMV_ADDR_MAX'(1) << swidth) - MMV_ADDR_MAX'(1);
        return (addr >> (awidth - swidth)) & mask;
    endfunction

endpackage

// File: rtl/mmv_splitter_rdtrack.sv
// Read tracker: counts outstanding reads, remembers which slave they target
// and produces the single-cycle response for reads to unmapped space.
// Reads are only allowed to one target at a time so responses stay ordered.
module mmv_splitter_rdtrack #(
    parameter int SLAVES  = 2,
    parameter int RDPENDS = 2,
    parameter int SWIDTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_acc,
    input  logic [SWIDTH:0]   i_sel_enc,
    input  logic [SLAVES-1:0] i_m_rval,
    output logic              o_rd_ok,
    output logic              o_ret,
    output logic [SWIDTH:0]   o_psel
);

    localparam int              CWIDTH   = $clog2(RDPENDS + 1);
    localparam logic [SWIDTH:0] UNMAPPED = (SWIDTH + 1)'(SLAVES);

    logic [CWIDTH-1:0] r_cnt;
    logic [SWIDTH:0]   r_psel;
    logic              r_urval;
    logic              w_prval;

    // Valid from the current read target; the unmapped target uses the
    // internal response register instead of a slave.
    always_comb begin
        w_prval = r_urval;
        for (int i = 0; i < SLAVES; i++) begin
            if (r_psel == (SWIDTH + 1)'(i)) begin
                w_prval = i_m_rval[i];
            end
        end
    end

    // A return only counts while reads are outstanding; a return in this
    // cycle does not free a slot for a request in the same cycle.
    assign o_ret   = (r_cnt != '0) & w_prval;
    assign o_rd_ok = (r_cnt == '0) |
                     ((i_sel_enc == r_psel) & (r_cnt < CWIDTH'(RDPENDS)));
    assign o_psel  = r_psel;

    // Outstanding count, current target and unmapped-response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_psel  <= '0;
            r_urval <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CWIDTH'(i_rd_acc) - CWIDTH'(o_ret);
            if (i_rd_acc && (r_cnt == '0)) begin
                r_psel <= i_sel_enc;
            end
            r_urval <= i_rd_acc & (i_sel_enc == UNMAPPED);
        end
    end

endmodule

// File: rtl/mmv_splitter.sv
// Routes one memory-mapped master to one of SLAVES slaves selected by the
// top address bits. Request path and mapped read responses are purely
// combinational; unmapped reads are answered one cycle later with zero data.
module mmv_splitter
    import mmv_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int SLAVES  = 2,
    parameter int RDPENDS = 2
) (
    input  logic                           reset,
    input  logic                           clk,
    input  logic [AWIDTH-1:0]              s_addr,
    input  logic                           s_wreq,
    input  logic [DWIDTH-1:0]              s_wdat,
    input  logic                           s_rreq,
    output logic [DWIDTH-1:0]              s_rdat,
    output logic                           s_rval,
    output logic                           s_busy,
    output logic [SLAVES-1:0][AWIDTH-1:0]  m_addr,
    output logic [SLAVES-1:0]              m_wreq,
    output logic [SLAVES-1:0][DWIDTH-1:0]  m_wdat,
    output logic [SLAVES-1:0]              m_rreq,
    input  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat,
    input  logic [SLAVES-1:0]              m_rval,
    input  logic [SLAVES-1:0]              m_busy
);

    localparam int              SWIDTH   = $clog2(SLAVES);
    localparam logic [SWIDTH:0] UNMAPPED = (SWIDTH + 1)'(SLAVES);

    logic [SWIDTH-1:0] w_sel;
    logic [SWIDTH:0]   w_sel_enc;
    logic              w_unmapped;
    logic              w_sbusy;
    logic              w_rd_ok;
    logic              w_rd_acc;
    logic              w_ret;
    logic [SWIDTH:0]   w_psel;

    assign w_sel      = SWIDTH'(mmv_slave_idx(MMV_ADDR_MAX'(s_addr), AWIDTH, SWIDTH));
    assign w_unmapped = {1'b0, w_sel} >= UNMAPPED;
    assign w_sel_enc  = w_unmapped ? UNMAPPED : {1'b0, w_sel};

    // Busy of the addressed slave; unmapped space is never busy.
    always_comb begin
        w_sbusy = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_sel_enc == (SWIDTH + 1)'(i)) begin
                w_sbusy = m_busy[i];
            end
        end
    end

    // A pure write never waits on the read tracker.
    assign s_busy   = w_sbusy | (s_rreq & ~w_rd_ok);
    assign w_rd_acc = s_rreq & ~s_busy;

    // Per-slave request strobes plus address/data broadcast. Unmapped
    // writes match no slave and are dropped.
    always_comb begin
        m_wreq = '0;
        m_rreq = '0;
        m_addr = '0;
        m_wdat = '0;
        for (int i = 0; i < SLAVES; i++) begin
            m_addr[i] = s_addr;
            m_wdat[i] = s_wdat;
            m_wreq[i] = s_wreq & ~reset & (w_sel_enc == (SWIDTH + 1)'(i));
            m_rreq[i] = s_rreq & w_rd_ok & ~reset & (w_sel_enc == (SWIDTH + 1)'(i));
        end
    end

    // Read data from the current target; the unmapped target returns zero.
    always_comb begin
        s_rdat = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_psel == (SWIDTH + 1)'(i)) begin
                s_rdat = m_rdat[i];
            end
        end
    end

    assign s_rval = w_ret;

    mmv_splitter_rdtrack #(
        .SLAVES  (SLAVES),
        .RDPENDS (RDPENDS),
        .SWIDTH  (SWIDTH)
    ) u_rdtrack (
        .clk       (clk),
        .reset     (reset),
        .i_rd_acc  (w_rd_acc),
        .i_sel_enc (w_sel_enc),
        .i_m_rval  (m_rval),
        .o_rd_ok   (w_rd_ok),
        .o_ret     (w_ret),
        .o_psel    (w_psel)
    );

endmodule

// File: tb/tb_mmv_splitter.sv
// Directed bench for mmv_splitter: a 4-slave instance for routing, latency,
// pending limit, target switch and reset, and a 3-slave instance for
// unmapped accesses. Expected read data is queued when a response is set up
// and popped when the DUT raises s_rval.
module tb_mmv_splitter;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // 4-slave instance
  logic [7:0]      s4_addr, s4_wdat, s4_rdat;
  logic            s4_wreq, s4_rreq, s4_rval, s4_busy;
  logic [3:0][7:0] m4_addr, m4_wdat, m4_rdat;
  logic [3:0]      m4_wreq, m4_rreq, m4_rval, m4_busy;

  // 3-slave instance
  logic [7:0]      s3_addr, s3_wdat, s3_rdat;
  logic            s3_wreq, s3_rreq, s3_rval, s3_busy;
  logic [2:0][7:0] m3_addr, m3_wdat, m3_rdat;
  logic [2:0]      m3_wreq, m3_rreq, m3_rval, m3_busy;

  logic [7:0] exp4_q[$];
  logic [7:0] exp3_q[$];
  logic [7:0] exp4_v, exp3_v;

  mmv_splitter #(.AWIDTH(8), .DWIDTH(8), .SLAVES(4), .RDPENDS(2)) u_dut4 (
    .reset (reset), .clk (clk),
    .s_addr (s4_addr), .s_wreq (s4_wreq), .s_wdat (s4_wdat), .s_rreq (s4_rreq),
    .s_rdat (s4_rdat), .s_rval (s4_rval), .s_busy (s4_busy),
    .m_addr (m4_addr), .m_wreq (m4_wreq), .m_wdat (m4_wdat), .m_rreq (m4_rreq),
    .m_rdat (m4_rdat), .m_rval (m4_rval), .m_busy (m4_busy)
  );

  mmv_splitter #(.AWIDTH(8), .DWIDTH(8), .SLAVES(3), .RDPENDS(2)) u_dut3 (
    .reset (reset), .clk (clk),
    .s_addr (s3_addr), .s_wreq (s3_wreq), .s_wdat (s3_wdat), .s_rreq (s3_rreq),
    .s_rdat (s3_rdat), .s_rval (s3_rval), .s_busy (s3_busy),
    .m_addr (m3_addr), .m_wreq (m3_wreq), .m_wdat (m3_wdat), .m_rreq (m3_rreq),
    .m_rdat (m3_rdat), .m_rval (m3_rval), .m_busy (m3_busy)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (s4_rval === 1'b1) begin
      if (exp4_q.size() == 0) begin
        check("d4_unexpected_rval", 32'd1, 32'd0);
      end else begin
        exp4_v = exp4_q.pop_front();
        check("d4_rdat", 32'(s4_rdat), 32'(exp4_v));
      end
    end else if (s4_rval !== 1'b0) begin
      check("d4_rval_known", 32'(s4_rval), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (s3_rval === 1'b1) begin
      if (exp3_q.size() == 0) begin
        check("d3_unexpected_rval", 32'd1, 32'd0);
      end else begin
        exp3_v = exp3_q.pop_front();
        check("d3_rdat", 32'(s3_rdat), 32'(exp3_v));
      end
    end else if (s3_rval !== 1'b0) begin
      check("d3_rval_known", 32'(s3_rval), 32'd0);
    end
  end

  // directed sequence
  initial begin
    reset = 1'b1;
    s4_addr = '0; s4_wdat = '0; s4_wreq = 0; s4_rreq = 0;
    m4_rdat = '0; m4_rval = '0; m4_busy = '0;
    s3_addr = '0; s3_wdat = '0; s3_wreq = 0; s3_rreq = 0;
    m3_rdat = '0; m3_rval = '0; m3_busy = '0;

    // reset-time outputs
    m4_rdat[0] = 8'h11;
    s4_wreq = 1; s4_addr = 8'h85; m4_busy[2] = 1'b1;
    #3;
    check("rst_cnt", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);
    check("rst_rval", 32'(s4_rval), 32'd0);
    check("rst_rdat", 32'(s4_rdat), 32'h11);
    check("rst_wreq", 32'(m4_wreq), 32'd0);
    check("rst_busy_follows", 32'(s4_busy), 32'd1);
    tick();
    s4_wreq = 0; m4_busy = '0; m4_rdat = '0;
    tick();
    reset = 1'b0;

    // write routing
    s4_addr = 8'h85; s4_wdat = 8'h3C; s4_wreq = 1;
    #2;
    check("wr_wreq", 32'(m4_wreq), 32'b0100);
    check("wr_addr", 32'(m4_addr[2]), 32'h85);
    check("wr_wdat", 32'(m4_wdat[2]), 32'h3C);
    check("wr_busy", 32'(s4_busy), 32'd0);
    m4_busy[2] = 1'b1;
    #1;
    check("wr_sbusy", 32'(s4_busy), 32'd1);
    tick();
    s4_wreq = 0; m4_busy = '0;
    #2;
    check("wr_one_cycle", 32'(m4_wreq), 32'd0);

    // read with latency 3
    tick();
    s4_addr = 8'h10; s4_rreq = 1;
    #2;
    check("rd_rreq", 32'(m4_rreq), 32'b0001);
    check("rd_busy", 32'(s4_busy), 32'd0);
    tick();
    s4_rreq = 0;
    #2;
    check("rd_rreq_once", 32'(m4_rreq), 32'd0);
    check("rd_cnt1", 32'(u_dut4.u_rdtrack.r_cnt), 32'd1);
    tick();
    tick();
    m4_rval[0] = 1'b1; m4_rdat[0] = 8'hA5; exp4_q.push_back(8'hA5);
    #2;
    check("rd_rval", 32'(s4_rval), 32'd1);
    check("rd_rdat", 32'(s4_rdat), 32'hA5);
    tick();
    m4_rval = '0;
    #2;
    check("rd_cnt0", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);

    // pending limit: three reads to slave 1, latency 5
    tick();
    s4_addr = 8'h40; s4_rreq = 1;
    #2;
    check("lim_a_busy", 32'(s4_busy), 32'd0);
    tick();
    s4_addr = 8'h44;
    #2;
    check("lim_b_busy", 32'(s4_busy), 32'd0);
    tick();
    s4_addr = 8'h48;
    #2;
    check("lim_c_busy", 32'(s4_busy), 32'd1);
    check("lim_c_rreq", 32'(m4_rreq), 32'd0);
    check("lim_cnt2", 32'(u_dut4.u_rdtrack.r_cnt), 32'd2);
    for (int k = 0; k < 2; k++) begin
      tick();
      #2;
      check("lim_wait_busy", 32'(s4_busy), 32'd1);
    end
    tick();
    m4_rval[1] = 1'b1; m4_rdat[1] = 8'hB1; exp4_q.push_back(8'hB1);
    #2;
    check("lim_nobypass_busy", 32'(s4_busy), 32'd1);
    tick();
    m4_rdat[1] = 8'hB2; exp4_q.push_back(8'hB2);
    #2;
    check("lim_c_accept_busy", 32'(s4_busy), 32'd0);
    check("lim_c_accept_rreq", 32'(m4_rreq), 32'b0010);
    tick();
    s4_rreq = 0; m4_rval = '0;
    #2;
    check("lim_cnt_after", 32'(u_dut4.u_rdtrack.r_cnt), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    m4_rval[1] = 1'b1; m4_rdat[1] = 8'hB3; exp4_q.push_back(8'hB3);
    tick();
    m4_rval = '0;
    #2;
    check("lim_cnt_drain", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);

    // target switch: pending to slave 0, then read to slave 3
    tick();
    s4_addr = 8'h10; s4_rreq = 1;
    tick();
    s4_addr = 8'hC0;
    #2;
    check("sw_busy", 32'(s4_busy), 32'd1);
    check("sw_rreq", 32'(m4_rreq), 32'd0);
    tick();
    m4_rval[3] = 1'b1; m4_rdat[3] = 8'hEE;
    #2;
    check("sw_spurious_rval", 32'(s4_rval), 32'd0);
    check("sw_busy2", 32'(s4_busy), 32'd1);
    tick();
    m4_rval = '0; m4_rval[0] = 1'b1; m4_rdat[0] = 8'h5A; exp4_q.push_back(8'h5A);
    #2;
    check("sw_busy_ret", 32'(s4_busy), 32'd1);
    check("sw_rreq_ret", 32'(m4_rreq), 32'd0);
    tick();
    m4_rval = '0;
    #2;
    check("sw_accept_busy", 32'(s4_busy), 32'd0);
    check("sw_accept_rreq", 32'(m4_rreq), 32'b1000);
    tick();
    s4_rreq = 0;
    #2;
    check("sw_cnt", 32'(u_dut4.u_rdtrack.r_cnt), 32'd1);
    check("sw_psel", 32'(u_dut4.u_rdtrack.r_psel), 32'd3);
    tick();
    m4_rval[3] = 1'b1; m4_rdat[3] = 8'h33; exp4_q.push_back(8'h33);
    tick();
    m4_rval = '0;
    #2;
    check("sw_cnt0", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);

    // reset mid-transaction with two reads pending
    tick();
    s4_addr = 8'h40; s4_rreq = 1;
    tick();
    s4_addr = 8'h44;
    tick();
    s4_addr = 8'h80;
    #2;
    check("mrst_cnt2", 32'(u_dut4.u_rdtrack.r_cnt), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check("mrst_cnt_async", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);
    check("mrst_rreq", 32'(m4_rreq), 32'd0);
    check("mrst_rval", 32'(s4_rval), 32'd0);
    tick();
    reset = 1'b0;
    m4_rval[1] = 1'b1; m4_rdat[1] = 8'h99;
    #2;
    check("mrst_stale_rval", 32'(s4_rval), 32'd0);
    check("mrst_new_busy", 32'(s4_busy), 32'd0);
    check("mrst_new_rreq", 32'(m4_rreq), 32'b0100);
    tick();
    s4_rreq = 0; m4_rval = '0;
    #2;
    check("mrst_cnt1", 32'(u_dut4.u_rdtrack.r_cnt), 32'd1);
    check("mrst_psel", 32'(u_dut4.u_rdtrack.r_psel), 32'd2);
    tick();
    m4_rval[2] = 1'b1; m4_rdat[2] = 8'h77; exp4_q.push_back(8'h77);
    tick();
    m4_rval = '0;
    #2;
    check("mrst_cnt0", 32'(u_dut4.u_rdtrack.r_cnt), 32'd0);

    // unmapped reads and write on the 3-slave instance
    m3_rdat = {8'hFF, 8'hFF, 8'hFF};
    tick();
    s3_addr = 8'hC0; s3_rreq = 1; exp3_q.push_back(8'h00);
    #2;
    check("um_rreq", 32'(m3_rreq), 32'd0);
    check("um_busy", 32'(s3_busy), 32'd0);
    tick();
    s3_addr = 8'hC4; exp3_q.push_back(8'h00);
    #2;
    check("um_rval1", 32'(s3_rval), 32'd1);
    check("um_rdat1", 32'(s3_rdat), 32'd0);
    check("um_b2b_busy", 32'(s3_busy), 32'd0);
    tick();
    s3_rreq = 0;
    #2;
    check("um_rval2", 32'(s3_rval), 32'd1);
    tick();
    #2;
    check("um_rval_end", 32'(s3_rval), 32'd0);
    check("um_cnt0", 32'(u_dut3.u_rdtrack.r_cnt), 32'd0);
    s3_addr = 8'hC0; s3_wdat = 8'h5C; s3_wreq = 1; m3_busy = 3'b111;
    #1;
    check("um_wr_wreq", 32'(m3_wreq), 32'd0);
    check("um_wr_busy", 32'(s3_busy), 32'd0);
    tick();
    s3_wreq = 0; m3_busy = '0;

    tick();
    tick();
    check("d4_queue_drained", 32'(exp4_q.size()), 32'd0);
    check("d3_queue_drained", 32'(exp3_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
